j11busarb: RTL and testbench
============================

Name: j11busarb

Overview:
Two-requester arbiter and sequencer for the 22-bit physical memory bus used by the DCJ11 interface. It accepts pulse-style transactions from the CPU-side interface (port 0) and from a DMA/console master (port 1). It serialises them onto one downstream memory port with a single outstanding transaction and round-robin fairness. A bus timeout returns an error acknowledge when the downstream port does not answer, so the CPU never hangs on nonexistent memory.

Parameters:
TIMEOUT, 255, cycles to wait for mem_ack after mem_req before forcing an error ack (1..2^TW-1)
TW, 8, width of the timeout counter

Ports:
clk  in  1  system clock
rstn  in  1  reset, asynchronous, active-low
cpu_req  in  1  one-cycle request pulse; cpu_wr/gp/addr/wdata held stable until cpu_ack
cpu_wr  in  1  1=write, 0=read
cpu_gp  in  1  I/O-page (general-purpose) space qualifier
cpu_addr  in  22  physical address
cpu_wdata  in  16  write data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  16  read data, valid from cpu_ack, held until next cpu_ack
cpu_err  out  1  timeout flag, valid with cpu_ack, held until next cpu_ack
dma_req, dma_wr, dma_gp, dma_addr[21:0], dma_wdata[15:0]  in  same as cpu_*
dma_ack, dma_rdata[15:0], dma_err  out  same as cpu_*
mem_req  out  1  one-cycle request pulse downstream
mem_wr  out  1  direction of current transaction
mem_gp  out  1  space qualifier of current transaction
mem_addr  out  22  address, held from mem_req until transaction ends
mem_wdata  out  16  write data, same hold rule
mem_ack  in  1  one-cycle downstream completion pulse
mem_rdata  in  16  read data, valid with mem_ack
owner  out  1  0=cpu, 1=dma; requester of current or last transaction
busy  out  1  high from grant until completion ack issued

Behaviour:
- Reset (rstn low, async): all outputs 0, both pending flags cleared, state IDLE, round-robin pointer favours cpu, counter 0. A transaction in flight is dropped; mem_ack arriving after reset release while IDLE is ignored.
- Per-port pending flag: set on a req pulse, cleared when that port's ack is issued. If set and clear happen in the same cycle, set wins (back-to-back request accepted). A req while already pending is ignored.
- States: IDLE, ISSUE, WAIT.
- IDLE: if any flag pending, grant. If both pending, grant the port not served last. Latch owner and the granted port's wr/gp/addr/wdata into mem_*. Go to ISSUE.
- ISSUE: mem_req=1 for exactly this cycle; counter cleared. Go to WAIT.
- WAIT: counter increments each cycle.
  - On mem_ack: owner's rdata<=mem_rdata, err<=0, ack pulses next cycle. Clear pending, update pointer, return to IDLE.
  - If the counter reaches TIMEOUT with no ack: owner's rdata<=0, err<=1, ack pulse. Return to IDLE.
  - mem_ack and timeout in the same cycle: treat as mem_ack.
- Latency: req in cycle k -> mem_req in cycle k+2. mem_ack in cycle m -> requester ack in cycle m+1. With zero-wait memory (mem_ack the cycle after mem_req), a transaction occupies 3 cycles; the next grant occurs the cycle after ack.
- mem_ack outside WAIT is ignored. The non-owner's ack/rdata/err are never disturbed.
- busy=1 from the ISSUE cycle through the ack cycle.
- Writes: mem_rdata is ignored and rdata is unchanged. Ack and err follow the same rules as reads.

Test Plan:
- CPU read, addr 22'h3FFF00, mem_ack+rdata 16'h1234 two cycles after mem_req -> mem_req at k+2, mem_addr 3FFF00, mem_wr 0, cpu_ack once with cpu_rdata 1234, cpu_err 0; dma_ack stays 0.
- cpu_req and dma_req in the same cycle after reset -> cpu granted first (owner 0), dma granted the cycle after cpu_ack. A second simultaneous pair -> dma now wins (round-robin).
- DMA write, dma_gp=1, addr 22'h17770, data 16'hA5A5 -> mem_wr 1, mem_gp 1, mem_wdata A5A5 held until mem_ack; dma_ack pulses and dma_rdata is unchanged.
- TIMEOUT=4, CPU read, no mem_ack -> cpu_ack with cpu_err 1, rdata 0 after 4 WAIT cycles. A late mem_ack is ignored and produces no extra ack.
- mem_ack coincident with timeout expiry, rdata 16'h0F0F -> cpu_err 0, cpu_rdata 0F0F.
- rstn low during WAIT -> all outputs 0 immediately. After release, a stale mem_ack produces no ack, and a fresh cpu_req completes normally.

Source files
------------

// File: rtl/j11busarb.sv
// Two-port round-robin arbiter for the 22-bit memory bus: one outstanding
// transaction, pulse handshakes, and a timeout that returns an error ack.
module j11busarb #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TW      = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic        cpu_gp,
    input  logic [21:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_ack,
    output logic [15:0] cpu_rdata,
    output logic        cpu_err,
    input  logic        dma_req,
    input  logic        dma_wr,
    input  logic        dma_gp,
    input  logic [21:0] dma_addr,
    input  logic [15:0] dma_wdata,
    output logic        dma_ack,
    output logic [15:0] dma_rdata,
    output logic        dma_err,
    output logic        mem_req,
    output logic        mem_wr,
    output logic        mem_gp,
    output logic [21:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        owner,
    output logic        busy
);

    localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t        state;
    logic          cpu_pend;
    logic          dma_pend;
    logic          prio_dma;
    logic [TW-1:0] cnt;

    logic grant_dma;
    logic done;
    logic clr_cpu;
    logic clr_dma;

    // Arbitration and completion detection; an ack wins over a coincident timeout.
    always_comb begin
        grant_dma = dma_pend & (~cpu_pend | prio_dma);
        done      = (state == WAIT) & (mem_ack | (cnt == LAST));
        clr_cpu   = done & ~owner;
        clr_dma   = done & owner;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            cpu_pend  <= 1'b0;
            dma_pend  <= 1'b0;
            prio_dma  <= 1'b0;
            cnt       <= '0;
            cpu_ack   <= 1'b0;
            cpu_rdata <= '0;
            cpu_err   <= 1'b0;
            dma_ack   <= 1'b0;
            dma_rdata <= '0;
            dma_err   <= 1'b0;
            mem_req   <= 1'b0;
            mem_wr    <= 1'b0;
            mem_gp    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            owner     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            cpu_ack  <= 1'b0;
            dma_ack  <= 1'b0;
            mem_req  <= 1'b0;
            // A new request in the completion cycle survives the clear.
            cpu_pend <= cpu_req | (cpu_pend & ~clr_cpu);
            dma_pend <= dma_req | (dma_pend & ~clr_dma);

            case (state)
                IDLE: begin
                    busy <= cpu_pend | dma_pend;
                    if (cpu_pend | dma_pend) begin
                        owner     <= grant_dma;
                        mem_wr    <= grant_dma ? dma_wr    : cpu_wr;
                        mem_gp    <= grant_dma ? dma_gp    : cpu_gp;
                        mem_addr  <= grant_dma ? dma_addr  : cpu_addr;
                        mem_wdata <= grant_dma ? dma_wdata : cpu_wdata;
                        mem_req   <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (done) begin
                        state    <= IDLE;
                        prio_dma <= ~owner;
                        if (owner) begin
                            dma_ack <= 1'b1;
                            dma_err <= ~mem_ack;
                            if (!mem_wr) dma_rdata <= mem_ack ? mem_rdata : 16'h0000;
                        end else begin
                            cpu_ack <= 1'b1;
                            cpu_err <= ~mem_ack;
                            if (!mem_wr) cpu_rdata <= mem_ack ? mem_rdata : 16'h0000;
                        end
                    end else begin
                        cnt <= cnt + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_j11busarb.sv
// Directed bench for j11busarb: arbitration order, latency, writes,
// timeout, ack/timeout collision and reset during a transaction.
module tb_j11busarb;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cpu_req = 1'b0, cpu_wr = 1'b0, cpu_gp = 1'b0;
    logic [21:0] cpu_addr = '0;
    logic [15:0] cpu_wdata = '0;
    logic        cpu_ack, cpu_err;
    logic [15:0] cpu_rdata;
    logic        dma_req = 1'b0, dma_wr = 1'b0, dma_gp = 1'b0;
    logic [21:0] dma_addr = '0;
    logic [15:0] dma_wdata = '0;
    logic        dma_ack, dma_err;
    logic [15:0] dma_rdata;
    logic        mem_req, mem_wr, mem_gp;
    logic [21:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic        owner, busy;

    int checks = 0;
    int errors = 0;

    j11busarb #(.TIMEOUT(4), .TW(8)) dut (
        .clk(clk), .rstn(rstn),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_gp(cpu_gp),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .dma_req(dma_req), .dma_wr(dma_wr), .dma_gp(dma_gp),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata), .dma_err(dma_err),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_gp(mem_gp),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .owner(owner), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    // Called in the request cycle; returns in the mem_req cycle (bounded).
    task automatic wait_issue(input string tag);
        int n;
        tick();
        cpu_req = 1'b0;
        dma_req = 1'b0;
        n = 1;
        while (!mem_req && n < 8) begin
            tick();
            n++;
        end
        chk(tag, 32'(n), 32'd2);
    endtask

    // mem_ack for the current cycle; returns one cycle later.
    task automatic pulse_ack(input logic [15:0] d);
        mem_ack   = 1'b1;
        mem_rdata = d;
        tick();
        mem_ack   = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_owner", 32'(owner), 0);
        chk("rst_cpu_ack", 32'(cpu_ack), 0);
        rstn = 1'b1;
        tick();
        tick();

        // Simultaneous pair after reset: cpu first, dma right after cpu_ack.
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_gp = 1'b0; cpu_addr = 22'h000200;
        dma_req = 1'b1; dma_wr = 1'b0; dma_gp = 1'b0; dma_addr = 22'h000300;
        wait_issue("pairA_lat");
        chk("pairA_owner0", 32'(owner), 0);
        chk("pairA_addr0", 32'(mem_addr), 32'h000200);
        chk("pairA_busy", 32'(busy), 1);
        tick();
        pulse_ack(16'h1111);
        chk("pairA_cpu_ack", 32'(cpu_ack), 1);
        chk("pairA_cpu_rdata", 32'(cpu_rdata), 32'h1111);
        chk("pairA_dma_ack0", 32'(dma_ack), 0);
        tick();
        chk("pairA_mem_req1", 32'(mem_req), 1);
        chk("pairA_owner1", 32'(owner), 1);
        chk("pairA_addr1", 32'(mem_addr), 32'h000300);
        tick();
        pulse_ack(16'h2222);
        chk("pairA_dma_ack", 32'(dma_ack), 1);
        chk("pairA_dma_rdata", 32'(dma_rdata), 32'h2222);
        chk("pairA_cpu_hold", 32'(cpu_rdata), 32'h1111);
        tick();

        // CPU read with two-cycle memory.
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_gp = 1'b0; cpu_addr = 22'h3FFF00;
        wait_issue("rd_lat");
        chk("rd_addr", 32'(mem_addr), 32'h3FFF00);
        chk("rd_wr", 32'(mem_wr), 0);
        tick();
        chk("rd_req_pulse", 32'(mem_req), 0);
        tick();
        pulse_ack(16'h1234);
        chk("rd_ack", 32'(cpu_ack), 1);
        chk("rd_rdata", 32'(cpu_rdata), 32'h1234);
        chk("rd_err", 32'(cpu_err), 0);
        chk("rd_dma_quiet", 32'(dma_ack), 0);
        tick();
        chk("rd_ack_once", 32'(cpu_ack), 0);
        chk("rd_rdata_hold", 32'(cpu_rdata), 32'h1234);

        // Second pair after a cpu transaction: dma wins.
        cpu_req = 1'b1; cpu_addr = 22'h000500;
        dma_req = 1'b1; dma_addr = 22'h000400;
        wait_issue("pairB_lat");
        chk("pairB_owner1", 32'(owner), 1);
        chk("pairB_addr", 32'(mem_addr), 32'h000400);
        tick();
        pulse_ack(16'h3333);
        chk("pairB_dma_ack", 32'(dma_ack), 1);
        tick();
        chk("pairB_owner0", 32'(owner), 0);
        chk("pairB_addr2", 32'(mem_addr), 32'h000500);
        tick();
        pulse_ack(16'h4444);
        chk("pairB_cpu_rdata", 32'(cpu_rdata), 32'h4444);
        tick();

        // DMA write in I/O space.
        dma_req = 1'b1; dma_wr = 1'b1; dma_gp = 1'b1;
        dma_addr = 22'h017770; dma_wdata = 16'hA5A5;
        wait_issue("wr_lat");
        chk("wr_mem_wr", 32'(mem_wr), 1);
        chk("wr_mem_gp", 32'(mem_gp), 1);
        chk("wr_wdata", 32'(mem_wdata), 32'hA5A5);
        chk("wr_addr", 32'(mem_addr), 32'h017770);
        tick();
        tick();
        chk("wr_wdata_hold", 32'(mem_wdata), 32'hA5A5);
        pulse_ack(16'hFFFF);
        chk("wr_dma_ack", 32'(dma_ack), 1);
        chk("wr_dma_err", 32'(dma_err), 0);
        chk("wr_rdata_keep", 32'(dma_rdata), 32'h3333);
        dma_wr = 1'b0; dma_gp = 1'b0;
        tick();

        // Timeout after 4 WAIT cycles; late ack ignored.
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 22'h000100;
        wait_issue("to_lat");
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("to_no_ack", 32'(cpu_ack), 0);
        end
        tick();
        chk("to_ack", 32'(cpu_ack), 1);
        chk("to_err", 32'(cpu_err), 1);
        chk("to_rdata", 32'(cpu_rdata), 0);
        pulse_ack(16'hBEEF);
        chk("late_cpu_ack", 32'(cpu_ack), 0);
        chk("late_dma_ack", 32'(dma_ack), 0);
        tick();
        chk("late_mem_req", 32'(mem_req), 0);
        chk("late_busy", 32'(busy), 0);
        chk("late_rdata", 32'(cpu_rdata), 0);

        // mem_ack in the expiry cycle counts as a real ack.
        cpu_req = 1'b1; cpu_addr = 22'h000101;
        wait_issue("col_lat");
        for (int i = 0; i < 4; i++) tick();
        pulse_ack(16'h0F0F);
        chk("col_ack", 32'(cpu_ack), 1);
        chk("col_err", 32'(cpu_err), 0);
        chk("col_rdata", 32'(cpu_rdata), 32'h0F0F);
        tick();

        // Reset during WAIT, stale ack, then a fresh transaction.
        cpu_req = 1'b1; cpu_addr = 22'h000102;
        wait_issue("rw_lat");
        tick();
        rstn = 1'b0;
        #1;
        chk("rw_busy", 32'(busy), 0);
        chk("rw_addr", 32'(mem_addr), 0);
        chk("rw_rdata", 32'(cpu_rdata), 0);
        tick();
        rstn = 1'b1;
        pulse_ack(16'hDEAD);
        chk("stale_ack", 32'(cpu_ack), 0);
        chk("stale_req", 32'(mem_req), 0);
        tick();
        chk("stale_ack2", 32'(cpu_ack), 0);
        cpu_req = 1'b1; cpu_addr = 22'h0123AB;
        wait_issue("fresh_lat");
        chk("fresh_addr", 32'(mem_addr), 32'h0123AB);
        tick();
        pulse_ack(16'h5A5A);
        chk("fresh_ack", 32'(cpu_ack), 1);
        chk("fresh_rdata", 32'(cpu_rdata), 32'h5A5A);
        chk("fresh_err", 32'(cpu_err), 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
